// File: rtl/gsim_host.sv
// Host-side driver/collector for the GSIM Gauss-Seidel solver core.
// Buffers a 16-word b vector and streams it into the solver. It then captures
// the 16-word x result into a register file that the host reads randomly.
// A watchdog aborts a solve whose result stream never starts.
module gsim_host #(
  parameter int N       = 16,
  parameter int TIMEOUT = 32768
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        start,
  input  logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        gsim_rst,
  output logic        in_en,
  output logic [15:0] b_in,
  input  logic        out_valid,
  input  logic [31:0] x_out
);

  localparam int WDOG_W = $clog2(TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_GAP, S_SEND, S_WAIT, S_CAPTURE, S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0]        wr_ptr_reg;
  logic [4:0]        b_cnt_reg;
  logic [3:0]        idx_reg;      // SEND element index, then CAPTURE word index
  logic [WDOG_W-1:0] wdog_reg;
  logic              timeout_reg;
  logic [15:0]       bbuf [0:N-1];
  logic [31:0]       xbuf [0:N-1];

  logic       host_side;
  logic       wr_ok;
  logic       start_ok;
  logic       x_we;
  logic [3:0] x_waddr;

  // The host may only touch the b buffer or launch a solve while nothing runs.
  // start is judged on the b_cnt value from before any same-cycle write.
  assign host_side = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign wr_ok     = wr_en && host_side;
  assign start_ok  = start && host_side && (b_cnt_reg == 5'd16);

  // Result words are positional: word 0 lands on the WAIT->CAPTURE edge.
  assign x_we    = out_valid && ((state_reg == S_WAIT) || (state_reg == S_CAPTURE));
  assign x_waddr = (state_reg == S_WAIT) ? 4'd0 : idx_reg;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: if (start_ok) state_next = S_RST;
      S_RST:          state_next = S_GAP;
      S_GAP:          state_next = S_SEND;
      S_SEND:         if (idx_reg == 4'd15) state_next = S_WAIT;
      S_WAIT: begin
        if (out_valid)                  state_next = S_CAPTURE;
        else if (wdog_reg == WDOG_LAST) state_next = S_DONE;
      end
      S_CAPTURE: if (!out_valid || idx_reg == 4'd15) state_next = S_DONE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    gsim_rst = 1'b0;
    in_en    = 1'b0;
    b_in     = 16'd0;
    case (state_reg)
      S_RST:     begin busy = 1'b1; gsim_rst = 1'b1; end
      S_GAP:     busy = 1'b1;
      S_SEND:    begin busy = 1'b1; in_en = 1'b1; b_in = bbuf[idx_reg]; end
      S_WAIT:    busy = 1'b1;
      S_CAPTURE: busy = 1'b1;
      S_DONE:    done = 1'b1;
      default:   ;
    endcase
  end

  // Host write pointer, element count, sequencing index, watchdog, and abort flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg  <= 4'd0;
      b_cnt_reg   <= 5'd0;
      idx_reg     <= 4'd0;
      wdog_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 4'd1;
        if (b_cnt_reg != 5'd16) b_cnt_reg <= b_cnt_reg + 5'd1;
      end
      if (start_ok) timeout_reg <= 1'b0;
      case (state_reg)
        S_GAP:  idx_reg <= 4'd0;
        S_SEND: begin
          idx_reg  <= idx_reg + 4'd1;
          wdog_reg <= '0;
        end
        S_WAIT: begin
          if (out_valid)                  idx_reg <= 4'd1;
          else if (wdog_reg == WDOG_LAST) timeout_reg <= 1'b1;
          else                            wdog_reg <= wdog_reg + 1'b1;
        end
        S_CAPTURE: begin
          if (!out_valid) timeout_reg <= 1'b1;
          else            idx_reg <= idx_reg + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // b buffer: survives reset so a host can inspect nothing but must rewrite it
  always_ff @(posedge clk) begin
    if (wr_ok) bbuf[wr_ptr_reg] <= wr_data;
  end

  // x buffer: one register per word, cleared on reset, written verbatim
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_xbuf
      logic [31:0] x_word_reg;
      // Capture this word when the positional stream reaches its index
      always_ff @(posedge clk) begin
        if (reset)                                x_word_reg <= 32'd0;
        else if (x_we && (x_waddr == 4'(gi)))     x_word_reg <= x_out;
      end
      assign xbuf[gi] = x_word_reg;
    end
  endgenerate

  assign rd_data = xbuf[rd_addr];
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_gsim_host.sv
// Self-checking bench for gsim_host with a behavioural GSIM solver model.
module tb_gsim_host;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset, wr_en, start;
  logic [15:0] wr_data;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        busy, done, timeout, gsim_rst, in_en;
  logic [15:0] b_in;
  logic        out_valid;
  logic [31:0] x_out;

  always #5 clk = ~clk;

  gsim_host #(.N(16), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .start(start),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .timeout(timeout), .gsim_rst(gsim_rst), .in_en(in_en), .b_in(b_in),
    .out_valid(out_valid), .x_out(x_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[%0t] FAIL %s: got %h required %h", $time, name, got, exp);
    end else begin
      $display("[%0t] ok   %s: %h", $time, name, got);
    end
  endtask

  // Solver model: x[i] = b[i] in Q16.16; result stream starts 4 cycles after
  // the 16th element. mode 0 normal, 1 never answers, 2 drops after 8 words.
  int          sv_mode = 0;
  logic [31:0] sv_x [16];
  int          sv_rx, sv_wait, sv_oidx;
  logic        sv_ov, sv_dropped;

  always @(posedge clk) begin
    if (reset || gsim_rst) begin
      sv_rx <= 0; sv_wait <= 0; sv_oidx <= 0; sv_ov <= 1'b0; sv_dropped <= 1'b0;
    end else begin
      if (in_en && sv_rx < 16) begin
        sv_x[sv_rx] <= {b_in, 16'h0000};
        sv_rx       <= sv_rx + 1;
      end
      if (sv_ov) begin
        if (sv_mode == 2 && sv_oidx == 7) begin
          sv_ov <= 1'b0; sv_dropped <= 1'b1;
        end else if (sv_oidx < 15) begin
          sv_oidx <= sv_oidx + 1;
        end
      end else if (sv_rx == 16 && !sv_dropped && sv_mode != 1) begin
        if (sv_wait == 3) sv_ov <= 1'b1;
        else              sv_wait <= sv_wait + 1;
      end
    end
  end
  assign out_valid = sv_ov;
  assign x_out     = sv_x[sv_oidx];

  // Scoreboard: expected b_in words queued at an accepted start, popped per in_en
  logic [15:0] b_q [$];
  int          in_en_cnt = 0;

  always @(negedge clk) begin
    if (in_en) begin
      in_en_cnt++;
      if (b_q.size() == 0) begin
        check("in_en_expected", 32'(in_en), 32'd0);
      end else begin
        logic [15:0] e;
        e = b_q.pop_front();
        check("b_in", 32'(b_in), 32'(e));
      end
    end
  end

  // Host-side reference of the b buffer
  logic [15:0] bmod [16];
  int          wptr = 0;
  int          bcnt = 0;
  logic [31:0] exp_x [16];

  typedef struct { logic [15:0] b; logic [31:0] x; } vec_t;
  vec_t vec [16];

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic host_op(input bit do_wr, input logic [15:0] v, input bit do_start);
    bit accept;
    accept = do_start && (bcnt == 16);
    if (do_wr) begin
      bmod[wptr] = v;
      wptr = (wptr + 1) % 16;
      if (bcnt < 16) bcnt++;
    end
    if (accept) begin
      in_en_cnt = 0;
      for (int k = 0; k < 16; k++) b_q.push_back(bmod[k]);
    end
    wr_en = do_wr; wr_data = v; start = do_start;
    tick;
    wr_en = 1'b0; start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      tick;
      n++;
    end
    check("done_reached", 32'(done), 32'd1);
  endtask

  task automatic readback(input string name);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      check(name, rd_data, exp_x[i]);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    b_q.delete();
    wptr = 0; bcnt = 0;
    for (int i = 0; i < 16; i++) exp_x[i] = 32'd0;
  endtask

  initial begin
    int n;
    reset = 1'b0; wr_en = 1'b0; start = 1'b0; wr_data = 16'd0; rd_addr = 4'd0;
    for (int i = 0; i < 16; i++) begin
      vec[i].b = 16'(i + 1);
      vec[i].x = 32'h0001_0000 * (i + 1);
    end

    // Reset state
    do_reset;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_gsim_rst", 32'(gsim_rst), 32'd0);
    check("rst_in_en", 32'(in_en), 32'd0);
    check("rst_b_in", 32'(b_in), 32'd0);
    readback("rst_xbuf");

    // 1: b = 1..16, normal solve
    sv_mode = 0;
    for (int i = 0; i < 16; i++) host_op(1'b1, vec[i].b, 1'b0);
    host_op(1'b0, 16'd0, 1'b1);
    wait_done(300, n);
    check("t1_timeout", 32'(timeout), 32'd0);
    check("t1_in_en_cycles", 32'(in_en_cnt), 32'd16);
    for (int i = 0; i < 16; i++) exp_x[i] = vec[i].x;
    readback("t1_xbuf");

    // 3: solver never answers -> abort exactly 2+16+TO cycles after start
    sv_mode = 1;
    host_op(1'b0, 16'd0, 1'b1);
    check("t3_cleared_done", 32'(done), 32'd0);
    wait_done(300, n);
    check("t3_latency", 32'(n), 32'(2 + 16 + TO));
    check("t3_timeout", 32'(timeout), 32'd1);
    readback("t3_xbuf_kept");

    // 4: stream drops after 8 words
    sv_mode = 2;
    for (int i = 0; i < 16; i++) host_op(1'b1, 16'(100 + i), 1'b0);
    host_op(1'b0, 16'd0, 1'b1);
    check("t4_timeout_cleared", 32'(timeout), 32'd0);
    wait_done(300, n);
    check("t4_timeout", 32'(timeout), 32'd1);
    for (int i = 0; i < 8; i++) exp_x[i] = {16'(100 + i), 16'h0000};
    readback("t4_xbuf");

    // 2: start with 15 elements ignored; same-cycle 16th write+start ignored
    do_reset;
    sv_mode = 0;
    for (int i = 0; i < 15; i++) host_op(1'b1, 16'h0200 + 16'(i), 1'b0);
    host_op(1'b0, 16'd0, 1'b1);
    check("t2_ign_busy", 32'(busy), 32'd0);
    check("t2_ign_gsim_rst", 32'(gsim_rst), 32'd0);
    host_op(1'b1, 16'h020F, 1'b1);
    check("t2_same_cycle_busy", 32'(busy), 32'd0);
    host_op(1'b0, 16'd0, 1'b1);
    check("t2_rst_pulse", 32'(gsim_rst), 32'd1);
    check("t2_rst_busy", 32'(busy), 32'd1);
    check("t2_rst_in_en", 32'(in_en), 32'd0);
    tick;
    check("t2_gap_gsim_rst", 32'(gsim_rst), 32'd0);
    check("t2_gap_in_en", 32'(in_en), 32'd0);
    check("t2_gap_busy", 32'(busy), 32'd1);
    tick;
    check("t2_send_in_en", 32'(in_en), 32'd1);
    wait_done(300, n);
    check("t2_timeout", 32'(timeout), 32'd0);
    for (int i = 0; i < 16; i++) exp_x[i] = {16'h0200 + 16'(i), 16'h0000};
    readback("t2_xbuf");

    // 5: reset during SEND at k=7
    host_op(1'b0, 16'd0, 1'b1);
    repeat (9) tick;
    check("t5_in_send", 32'(in_en), 32'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    b_q.delete();
    wptr = 0; bcnt = 0;
    for (int i = 0; i < 16; i++) exp_x[i] = 32'd0;
    check("t5_in_en", 32'(in_en), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    host_op(1'b0, 16'd0, 1'b1);
    check("t5_start_ignored", 32'(busy), 32'd0);
    check("t5_no_gsim_rst", 32'(gsim_rst), 32'd0);
    readback("t5_xbuf_cleared");

    // 6: 17 writes, entry 0 overwritten by w16
    for (int i = 0; i < 17; i++) host_op(1'b1, 16'hF000 + 16'(i), 1'b0);
    host_op(1'b0, 16'd0, 1'b1);
    wait_done(300, n);
    check("t6_in_en_cycles", 32'(in_en_cnt), 32'd16);
    check("t6_timeout", 32'(timeout), 32'd0);
    for (int i = 0; i < 16; i++)
      exp_x[i] = (i == 0) ? 32'hF010_0000 : {16'hF000 + 16'(i), 16'h0000};
    readback("t6_xbuf");
    check("t6_queue_drained", 32'(b_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_time_limit: got expired required finish");
    $fatal(1, "time limit");
  end

endmodule
